mod5_job_sequencer: RTL and testbench

- Feeds the serial modulo-5 unit and collects its results.
- Buffers incoming bytes in a small FIFO and launches one job at a time: a one-cycle Start pulse with the byte held on the data bus.
- Waits for the unit's Done pulse, captures the 4-bit modulo result, and presents byte plus result on a valid/ready output port.
- Sits between the board input/driver logic and the modulo core; also guards against a hung core with a timeout.

---
 rtl/mod5_job_sequencer.sv | 100 ++++++++++
 tb/tb_mod5_job_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod5_job_sequencer.sv
// mod5_job_sequencer: buffers bytes and runs them one at a time through the serial mod-5 core, with a hung-core timeout
module mod5_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    output logic                     core_start,
    output logic [7:0]               core_data,
    input  logic                     core_done,
    input  logic [3:0]               core_mod,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [3:0]               out_mod,
    output logic                     out_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t state, next_state;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] timer;
    logic push, pop, finish;

    // state register
    always_ff @(posedge clk)
        state <= reset ? IDLE : next_state;

    // next state: one job in flight; a Done in the last timeout cycle still counts as success
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = |count ? LAUNCH : IDLE;
            LAUNCH:  next_state = WAIT;
            WAIT:    next_state = finish ? HOLD : WAIT;
            HOLD:    next_state = out_ready ? IDLE : HOLD;
            default: next_state = IDLE;
        endcase
    end

    // outputs and handshakes decoded from state and occupancy
    always_comb begin
        core_start = state == LAUNCH;
        out_valid  = state == HOLD;
        busy       = state != IDLE;
        in_ready   = count != FULL;
        push       = in_valid && in_ready;
        pop        = state == IDLE && |count;
        finish     = core_done || timer == TLAST;
    end

    // FIFO storage; occupancy alone decides which entries are meaningful
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    // FIFO pointers wrap naturally at DEPTH; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // job datapath: core_data doubles as the job register and only changes on a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            core_data <= '0;
            timer     <= '0;
            out_data  <= '0;
            out_mod   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (pop) core_data <= mem[rd_ptr];
            if (state == LAUNCH) timer <= '0;
            if (state == WAIT) begin
                timer <= timer + 1'b1;
                if (finish) begin
                    out_data <= core_data;
                    out_mod  <= core_done ? core_mod : 4'd0;
                    out_err  <= !core_done;
                end
            end
        end
    end
endmodule

// File: tb/tb_mod5_job_sequencer.sv
// tb_mod5_job_sequencer: random and directed jobs against a queue-based model of the sequencer
module tb_mod5_job_sequencer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 32;

    typedef struct {
        logic [7:0] data;
        logic [3:0] mod;
        logic       err;
        int         cyc;
    } exp_t;

    logic clk, reset, in_valid, in_ready, core_start, core_done, out_valid, out_ready, out_err, busy;
    logic spur_done, dut_done;
    logic [7:0] in_data, core_data, out_data;
    logic [3:0] core_mod, spur_mod, dut_mod, out_mod;
    logic [2:0] count;

    logic [7:0] in_q[$];
    exp_t exp_q[$];
    int n_cmp = 0, n_err = 0, n_start = 0, cyc = 0, force_delay = -1;

    assign dut_done = core_done | spur_done;
    assign dut_mod  = spur_done ? spur_mod : core_mod;

    mod5_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .core_data(core_data), .core_done(dut_done), .core_mod(dut_mod),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mod(out_mod),
        .out_err(out_err), .busy(busy), .count(count)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_try(input logic [7:0] b, output logic ok);
        in_valid = 1;
        in_data  = b;
        @(negedge clk);
        ok = in_ready;
        if (ok) in_q.push_back(b);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic push(input logic [7:0] b);
        logic ok;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) push_try(b, ok);
        if (!ok) flag("push_timeout");
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1;
        while ((in_q.size() != 0 || exp_q.size() != 0 || busy || count != 0) && t < 3000) begin
            step();
            t++;
        end
        if (t >= 3000) flag("drain_timeout");
    endtask

    // core model: answers each Start with byte%5 after a chosen delay, 0 = never answers
    initial begin
        int d;
        logic [7:0] b;
        exp_t e;
        core_done = 0;
        core_mod  = 0;
        forever begin
            @(negedge clk);
            if (!reset && core_start) begin
                if (in_q.size() == 0) begin
                    flag("start_without_job");
                    b = core_data;
                end else begin
                    b = in_q.pop_front();
                end
                chk("core_data", core_data, b);
                if (force_delay >= 0) d = force_delay;
                else begin
                    int r;
                    r = $urandom_range(19);
                    d = r < 14 ? $urandom_range(12, 1) : r < 17 ? TIMEOUT : 0;
                end
                e.data = b;
                e.err  = d == 0 || d > TIMEOUT;
                e.mod  = e.err ? 4'd0 : 4'(b % 5);
                e.cyc  = cyc + (e.err ? TIMEOUT : d) + 1;
                exp_q.push_back(e);
                if (!e.err) begin
                    repeat (d) @(posedge clk);
                    #1;
                    core_done = 1;
                    core_mod  = 4'(b % 5);
                    @(posedge clk);
                    #1;
                    core_done = 0;
                    core_mod  = 0;
                end
            end
        end
    end

    // monitor: launch spacing, core_data stability, result ordering/timing and hold stability
    initial begin
        int last_start;
        logic pv, pr, have_cd, perr;
        logic [7:0] pcd, pd;
        logic [3:0] pm;
        exp_t e;
        last_start = -100;
        pv = 0; pr = 0; have_cd = 0; perr = 0; pcd = 0; pd = 0; pm = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0; pr = 0; have_cd = 0;
                last_start = -100;
            end else begin
                if (core_start) begin
                    chk("start_gap_ge4", 32'(cyc - last_start >= 4), 1);
                    last_start = cyc;
                    n_start++;
                end
                if (busy && !core_start && have_cd) chk("core_data_hold", core_data, pcd);
                pcd = core_data;
                have_cd = 1;
                if (pv && pr) chk("valid_drop", out_valid, 0);
                else if (out_valid && pv) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_mod", out_mod, pm);
                    chk("hold_err", out_err, perr);
                end else if (out_valid) begin
                    if (exp_q.size() == 0) flag("unexpected_result");
                    else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_mod", out_mod, e.mod);
                        chk("out_err", out_err, e.err);
                        chk("out_cycle", cyc, e.cyc);
                        chk("out_mod_range", 32'(out_mod <= 4), 1);
                    end
                end
                pv = out_valid; pr = out_ready; pd = out_data; pm = out_mod; perr = out_err;
            end
        end
    end

    // directed scenarios, a random phase, then reset in mid-job
    initial begin
        logic ok;
        int s0, t;
        reset = 1; in_valid = 0; in_data = 0; out_ready = 0;
        spur_done = 0; spur_mod = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_data", core_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_mod", out_mod, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        step();

        force_delay = 10; out_ready = 1;
        push(8'h0D);
        drain();

        force_delay = 3;
        push(8'hFF); push(8'h07); push(8'h00);
        drain();

        out_ready = 0;
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        push_try(8'h99, ok);
        chk("full_refuse", ok, 0);
        @(negedge clk);
        chk("count_full", count, 4);
        step();
        s0 = n_start;
        repeat (5) step();
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        step();
        spur_done = 1; spur_mod = 4'h9;
        step();
        spur_done = 0; spur_mod = 0;
        repeat (13) step();
        chk("no_launch_in_hold", n_start - s0, 0);
        drain();

        spur_done = 1; spur_mod = 4'h2;
        step();
        spur_done = 0; spur_mod = 0;
        @(negedge clk);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_valid", out_valid, 0);
        step();

        force_delay = 0; s0 = n_start; t = 0;
        push(8'hA5);
        while (n_start == s0 && t < 50) begin step(); t++; end
        force_delay = 5;
        push(8'h3C);
        drain();

        force_delay = TIMEOUT;
        push(8'h5A);
        drain();

        force_delay = -1;
        for (int i = 0; i < 300; i++) begin
            out_ready = $urandom_range(3) != 0;
            if ($urandom_range(1) == 1) push_try(8'($urandom), ok);
            else step();
        end
        drain();

        force_delay = 5; s0 = n_start; t = 0;
        push(8'h11); push(8'h22); push(8'h33);
        while (n_start == s0 && t < 50) begin step(); t++; end
        @(negedge clk);
        chk("pre_reset_count", count, 2);
        chk("pre_reset_busy", busy, 1);
        step();
        reset = 1;
        step();
        reset = 0;
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_start", core_start, 0);
        repeat (12) step();
        @(negedge clk);
        chk("late_done_busy", busy, 0);
        chk("late_done_valid", out_valid, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
